ternary_rq_mul: RTL and testbench

- Downstream consumer of the ternary sampler's r-trit stream (poly_r) and of the unpacked public key h.
- Computes c = r*h in Rq = Z_q[x]/(x^N - 1), with q = 2^LOGQ, by serial trit-by-coefficient accumulation.
- Streams the N result coefficients out to the next stage (add Lift(m), then pack).
- Load h, multiply, unload are three sequential phases, each with a valid/ready handshake.

---
 rtl/ntru_pkg.sv | 29 ++
 rtl/ternary_rq_mul_if.sv | 26 ++
 rtl/rq_mac_lane.sv | 32 +++
 rtl/ternary_rq_mul.sv | 152 +++++++++++++++
 tb/tb_ternary_rq_mul.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntru_pkg.sv
// Shared types and helpers for the NTRU Rq ternary multiplier.
// Coefficients are LOGQ-bit, and all arithmetic wraps mod 2^LOGQ.
package ntru_pkg;

  localparam int unsigned N_DEFAULT = 701;
  localparam int unsigned LOGQ      = 13;

  typedef logic [LOGQ-1:0] coef_t;
  typedef logic [1:0]      trit_t;

  localparam trit_t TRIT_ZERO = 2'b00;
  localparam trit_t TRIT_POS  = 2'b01;
  localparam trit_t TRIT_NEG  = 2'b10;
  localparam trit_t TRIT_BAD  = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD_H, MUL, OUT} state_e;

  // acc + t*h mod 2^LOGQ. The illegal code 11 behaves like a zero trit.
  function automatic coef_t trit_mac(coef_t acc, coef_t h, trit_t trit);
    coef_t res;
    case (trit)
      TRIT_POS: res = acc + h;
      TRIT_NEG: res = acc - h;
      default:  res = acc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ternary_rq_mul_if.sv
// Handshake bundle for the ternary multiplier: the h load, r trit and c result streams.
interface ternary_rq_mul_if;
  import ntru_pkg::*;

  coef_t h_data;
  logic  h_valid;
  logic  h_ready;
  trit_t r_trit;
  logic  r_valid;
  logic  r_ready;
  coef_t c_data;
  logic  c_valid;
  logic  c_ready;
  logic  c_last;

  modport master (
    output h_data, h_valid, r_trit, r_valid, c_ready,
    input  h_ready, r_ready, c_data, c_valid, c_last
  );

  modport slave (
    input  h_data, h_valid, r_trit, r_valid, c_ready,
    output h_ready, r_ready, c_data, c_valid, c_last
  );

endinterface

// File: rtl/rq_mac_lane.sv
// One accumulator lane: trit multiply-accumulate in MUL, shift toward lane 0 in OUT.
module rq_mac_lane
  import ntru_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  mac_en,
  input  logic  shift,
  input  coef_t shift_in,
  input  coef_t h,
  input  trit_t trit,
  output coef_t acc
);

  coef_t acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (mac_en) begin
      acc_q <= trit_mac(acc_q, h, trit);
    end else if (shift) begin
      acc_q <= shift_in;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/ternary_rq_mul.sv
// c = r*h in Z_q[x]/(x^N - 1): serial load of h, one trit per beat across N parallel lanes,
// then the lanes drain through lane 0 as a coefficient stream.
module ternary_rq_mul
  import ntru_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  ternary_rq_mul_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned     CW       = $clog2(N);
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic hrot_we, hrot_rot;
  logic acc_clr, acc_en, acc_shift;

  coef_t hrot_q   [N];
  coef_t acc      [N];
  coef_t shift_in [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    done_d      = 1'b0;
    hrot_we     = 1'b0;
    hrot_rot    = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    acc_shift   = 1'b0;
    bus.h_ready = 1'b0;
    bus.r_ready = 1'b0;
    bus.c_valid = 1'b0;
    bus.c_last  = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.h_ready = 1'b1;
        if (bus.h_valid) begin
          hrot_we = 1'b1;
          cnt_d   = CW'(1);
          err_d   = 1'b0;
          state_d = LOAD_H;
        end
      end
      LOAD_H: begin
        bus.h_ready = 1'b1;
        if (bus.h_valid) begin
          hrot_we = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            acc_clr = 1'b1;
            state_d = MUL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      MUL: begin
        bus.r_ready = 1'b1;
        if (bus.r_valid) begin
          acc_en   = 1'b1;
          hrot_rot = 1'b1;
          if (bus.r_trit == TRIT_BAD) err_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = OUT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      OUT: begin
        bus.c_valid = 1'b1;
        bus.c_last  = (cnt_q == CNT_LAST);
        if (bus.c_ready) begin
          acc_shift = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Rotating h one place per trit aligns h_((k-i) mod N) with lane k on beat i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hrot_q <= '{default: '0};
    end else if (hrot_we) begin
      hrot_q[cnt_q] <= bus.h_data;
    end else if (hrot_rot) begin
      hrot_q[0] <= hrot_q[N-1];
      for (int k = 1; k < int'(N); k++) hrot_q[k] <= hrot_q[k-1];
    end
  end

  for (genvar k = 0; k < int'(N); k++) begin : g_lane
    if (k == int'(N) - 1) begin : g_tail
      assign shift_in[k] = '0;
    end else begin : g_body
      assign shift_in[k] = acc[k+1];
    end

    rq_mac_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (acc_clr),
      .mac_en   (acc_en),
      .shift    (acc_shift),
      .shift_in (shift_in[k]),
      .h        (hrot_q[k]),
      .trit     (bus.r_trit),
      .acc      (acc[k])
    );
  end

  assign bus.c_data = acc[0];
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ternary_rq_mul.sv
// Directed and randomised checks of ternary_rq_mul at N=5 plus one long N=701 run.
module tb_ternary_rq_mul;
  import ntru_pkg::*;

  localparam int unsigned NS = 5;
  localparam int unsigned NL = 701;

  typedef logic [NS-1:0][12:0] cvec_t;
  typedef logic [NS-1:0][1:0]  rvec_t;

  typedef struct packed {
    cvec_t h;
    rvec_t r;
    cvec_t c;
    logic  err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ternary_rq_mul_if bif5 ();
  ternary_rq_mul_if bifl ();
  logic busy5, done5, err5, busyl, donel, errl;

  ternary_rq_mul #(.N(NS)) dut5 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bif5),
    .busy (busy5),
    .done (done5),
    .err  (err5)
  );

  ternary_rq_mul #(.N(NL)) dutl (
    .clk  (clk),
    .rst  (rst),
    .bus  (bifl),
    .busy (busyl),
    .done (donel),
    .err  (errl)
  );

  int checks = 0;
  int errors = 0;

  coef_t mh [NL];
  trit_t mr [NL];
  coef_t mc [NL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Reference cyclic convolution over the first n entries of mh/mr.
  task automatic model(input int n);
    coef_t s;
    int    j;
    for (int k = 0; k < n; k++) begin
      s = '0;
      for (int i = 0; i < n; i++) begin
        j = (k - i + n) % n;
        if (mr[i] == 2'b01) s = s + mh[j];
        else if (mr[i] == 2'b10) s = s - mh[j];
      end
      mc[k] = s;
    end
  endtask

  function automatic cvec_t pk13(input int a0, input int a1, input int a2, input int a3,
                                 input int a4);
    cvec_t v;
    v[0] = 13'(a0); v[1] = 13'(a1); v[2] = 13'(a2); v[3] = 13'(a3); v[4] = 13'(a4);
    return v;
  endfunction

  function automatic rvec_t pk2(input int a0, input int a1, input int a2, input int a3,
                                input int a4);
    rvec_t v;
    v[0] = 2'(a0); v[1] = 2'(a1); v[2] = 2'(a2); v[3] = 2'(a3); v[4] = 2'(a4);
    return v;
  endfunction

  task automatic load5(input cvec_t h);
    logic acc;
    int   budget;
    for (int i = 0; i < int'(NS); i++) begin
      bif5.h_valid = 1'b1;
      bif5.h_data  = h[i];
      budget = 20;
      do begin
        @(negedge clk);
        acc = bif5.h_ready;
        @(posedge clk); #1;
        budget--;
      end while (!acc && budget > 0);
      if (!acc) timeout("h load");
    end
    bif5.h_valid = 1'b0;
  endtask

  task automatic mul5(input rvec_t r, input int count, input bit stall);
    logic acc;
    int   budget;
    for (int i = 0; i < count; i++) begin
      bif5.r_trit = r[i];
      budget = 50;
      do begin
        bif5.r_valid = stall ? 1'($urandom_range(1)) : 1'b1;
        @(negedge clk);
        acc = bif5.r_valid && bif5.r_ready;
        @(posedge clk); #1;
        budget--;
      end while (!acc && budget > 0);
      if (!acc) timeout("r trit");
    end
    bif5.r_valid = 1'b0;
    bif5.r_trit  = 2'b00;
  endtask

  task automatic run5(input string tag, input vec_t v, input bit stall);
    int i;
    int budget;
    load5(v.h);
    check({tag, " h_ready in MUL"}, 32'(bif5.h_ready), 0);
    mul5(v.r, NS, stall);
    check({tag, " first c_valid"}, 32'(bif5.c_valid), 1);
    i = 0;
    budget = 100;
    while (i < int'(NS) && budget > 0) begin
      bif5.c_ready = stall ? 1'($urandom_range(1)) : 1'b1;
      @(negedge clk);
      if (bif5.c_valid && bif5.c_ready) begin
        check($sformatf("%s c[%0d]", tag, i), 32'(bif5.c_data), 32'(v.c[i]));
        check($sformatf("%s c_last[%0d]", tag, i), 32'(bif5.c_last),
              32'(i == int'(NS) - 1));
        i++;
      end
      @(posedge clk); #1;
      budget--;
    end
    if (i < int'(NS)) timeout({tag, " c unload"});
    bif5.c_ready = 1'b0;
    check({tag, " done pulse"}, 32'(done5), 1);
    check({tag, " busy after"}, 32'(busy5), 0);
    check({tag, " err"}, 32'(err5), 32'(v.err));
    @(posedge clk); #1;
    check({tag, " done cleared"}, 32'(done5), 0);
  endtask

  task automatic runl();
    logic  acc;
    int    budget;
    int    i;
    int    unstable;
    coef_t held;
    for (int k = 0; k < int'(NL); k++) begin
      mh[k] = coef_t'($urandom);
      mr[k] = trit_t'($urandom_range(2));
    end
    model(NL);
    for (int k = 0; k < int'(NL); k++) begin
      bifl.h_valid = 1'b1;
      bifl.h_data  = mh[k];
      budget = 20;
      do begin
        @(negedge clk);
        acc = bifl.h_ready;
        @(posedge clk); #1;
        budget--;
      end while (!acc && budget > 0);
      if (!acc) timeout("n701 h load");
    end
    bifl.h_valid = 1'b0;
    for (int k = 0; k < int'(NL); k++) begin
      bifl.r_valid = 1'b1;
      bifl.r_trit  = mr[k];
      budget = 20;
      do begin
        @(negedge clk);
        acc = bifl.r_ready;
        @(posedge clk); #1;
        budget--;
      end while (!acc && budget > 0);
      if (!acc) timeout("n701 r trit");
    end
    bifl.r_valid = 1'b0;
    i = 0;
    budget = 2000;
    unstable = 0;
    while (i < int'(NL) && budget > 0) begin
      if (i == 100) begin
        bifl.c_ready = 1'b0;
        @(negedge clk);
        held = bifl.c_data;
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          if (bifl.c_data !== held || !bifl.c_valid) unstable++;
        end
        check("n701 hold stable", 32'(unstable), 0);
        @(posedge clk); #1;
      end
      bifl.c_ready = 1'b1;
      @(negedge clk);
      if (bifl.c_valid) begin
        check($sformatf("n701 c[%0d]", i), 32'(bifl.c_data), 32'(mc[i]));
        if (i == int'(NL) - 1) check("n701 c_last", 32'(bifl.c_last), 1);
        i++;
      end
      @(posedge clk); #1;
      budget--;
    end
    if (i < int'(NL)) timeout("n701 c unload");
    bifl.c_ready = 1'b0;
    check("n701 done", 32'(donel), 1);
    check("n701 err", 32'(errl), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    vec_t rv;

    tbl[0] = '{h: pk13(1, 2, 3, 4, 5), r: pk2(1, 0, 0, 0, 0),
               c: pk13(1, 2, 3, 4, 5), err: 1'b0};
    tbl[1] = '{h: pk13(1, 2, 3, 4, 5), r: pk2(0, 1, 0, 0, 0),
               c: pk13(5, 1, 2, 3, 4), err: 1'b0};
    tbl[2] = '{h: pk13(1, 2, 3, 4, 5), r: pk2(2, 0, 0, 0, 0),
               c: pk13(8191, 8190, 8189, 8188, 8187), err: 1'b0};
    tbl[3] = '{h: pk13(8191, 8191, 8191, 8191, 8191), r: pk2(1, 1, 1, 1, 1),
               c: pk13(8187, 8187, 8187, 8187, 8187), err: 1'b0};
    // Trit 11 at index 2 must act as zero: c_k = h_k - h_(k+1).
    tbl[4] = '{h: pk13(1, 2, 3, 4, 5), r: pk2(1, 0, 3, 0, 2),
               c: pk13(8191, 8191, 8191, 8191, 4), err: 1'b1};

    rst = 1'b0;
    {bif5.h_valid, bif5.r_valid, bif5.c_ready} = '0;
    {bifl.h_valid, bifl.r_valid, bifl.c_ready} = '0;
    bif5.h_data = '0; bif5.r_trit = '0;
    bifl.h_data = '0; bifl.r_trit = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset h_ready", 32'(bif5.h_ready), 1);
    check("reset r_ready", 32'(bif5.r_ready), 0);
    check("reset c_valid", 32'(bif5.c_valid), 0);
    check("reset c_last", 32'(bif5.c_last), 0);
    check("reset c_data", 32'(bif5.c_data), 0);
    check("reset busy", 32'(busy5), 0);
    check("reset done", 32'(done5), 0);
    check("reset err", 32'(err5), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // r offered while idle must be ignored
    bif5.r_valid = 1'b1;
    bif5.r_trit  = 2'b01;
    @(negedge clk);
    check("idle r_ready", 32'(bif5.r_ready), 0);
    @(posedge clk); #1;
    check("idle busy", 32'(busy5), 0);
    bif5.r_valid = 1'b0;

    for (int t = 0; t < 5; t++) run5($sformatf("vec%0d", t), tbl[t], 1'b0);

    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < int'(NS); k++) begin
        mh[k] = coef_t'($urandom);
        mr[k] = trit_t'($urandom_range(2));
      end
      model(NS);
      for (int k = 0; k < int'(NS); k++) begin
        rv.h[k] = mh[k];
        rv.r[k] = mr[k];
        rv.c[k] = mc[k];
      end
      rv.err = 1'b0;
      run5($sformatf("rand%0d", t), rv, 1'b1);
    end

    runl();

    // Abort mid-multiply: err set by an illegal trit, then async reset.
    load5(pk13(1, 2, 3, 4, 5));
    mul5(pk2(3, 1, 0, 0, 0), 2, 1'b0);
    check("abort err before", 32'(err5), 1);
    check("abort busy before", 32'(busy5), 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("abort busy", 32'(busy5), 0);
    check("abort c_valid", 32'(bif5.c_valid), 0);
    check("abort err", 32'(err5), 0);
    check("abort h_ready", 32'(bif5.h_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post-abort r_ready", 32'(bif5.r_ready), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
